// File: rtl/task_seq_pkg.sv
// -----------------------------------------------------------------------------
// task_seq_pkg
// Shared types and helpers for the task sequencer:
//   seq_state_t   - sequencer FSM state encoding
//   next_t        - result of a priority search over the enable mask
//   task_w()      - width of the task index, max(1, clog2(n))
//   timer_w()     - width of the watchdog timer, clog2(timeout+1) (min 1)
//   next_enabled()- lowest set mask bit at or above a starting index
// -----------------------------------------------------------------------------
package task_seq_pkg;

  localparam int MAX_TASKS = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    DONE,
    ERROR
  } seq_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } next_t;

  function automatic int task_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int timer_w(input int t);
    return (t <= 1) ? 1 : $clog2(t + 1);
  endfunction

  // Lowest set bit of mask whose index is >= from. Scanning downwards lets
  // the last hit (the lowest index) win without a break.
  function automatic next_t next_enabled(input logic [MAX_TASKS-1:0] mask,
                                         input int                   from);
    next_t r;
    r = '0;
    for (int i = MAX_TASKS - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// -----------------------------------------------------------------------------
// seq_watchdog
// Counts cycles while enabled and flags expiry on the last permitted cycle.
//   i_clk      - clock
//   i_rst_n    - asynchronous active-low reset
//   i_clear    - synchronous clear of the timer (highest priority after reset)
//   i_enable   - count this cycle
//   o_expired  - timer has reached TIMEOUT_CYCLES-1 while enabled
// Only instantiated for TIMEOUT_CYCLES > 0.
// -----------------------------------------------------------------------------
module seq_watchdog
  import task_seq_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 8,
  localparam int TIMER_W        = timer_w(TIMEOUT_CYCLES)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [TIMER_W-1:0] r_timer;
  logic               w_at_limit;

  assign w_at_limit = (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign o_expired  = i_enable & w_at_limit;

  // Saturate at the limit so the counter can never wrap back to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (i_clear) begin
      r_timer <= '0;
    end else if (i_enable && !w_at_limit) begin
      r_timer <= r_timer + 1'b1;
    end
  end

endmodule

// File: rtl/task_sequencer.sv
// -----------------------------------------------------------------------------
// task_sequencer
// Launches enabled task FSMs in index order with one-cycle start pulses and
// waits for each finish before launching the next. Optional loop mode,
// per-task watchdog and an abort that returns to IDLE from anywhere.
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   i_go             - start a sequence (accepted in IDLE/DONE/ERROR)
//   i_abort          - return to IDLE, highest priority
//   i_enable         - task enable mask, latched on an accepted go
//   i_finish         - per-task finish (level or pulse)
//   o_start          - one-hot start pulse to the current task
//   o_busy           - in START or WAIT
//   o_done           - in DONE
//   o_timeout_err    - in ERROR
//   o_cur_task       - index of the current / last task
// All outputs decode registered state only.
// -----------------------------------------------------------------------------
module task_sequencer
  import task_seq_pkg::*;
#(
  parameter  int NUM_TASKS      = 3,
  parameter  int TIMEOUT_CYCLES = 0,
  parameter  bit LOOP           = 1'b0,
  localparam int TASK_W         = task_w(NUM_TASKS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_go,
  input  logic                 i_abort,
  input  logic [NUM_TASKS-1:0] i_enable,
  input  logic [NUM_TASKS-1:0] i_finish,
  output logic [NUM_TASKS-1:0] o_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_timeout_err,
  output logic [TASK_W-1:0]    o_cur_task
);

  seq_state_t           r_state;
  logic [TASK_W-1:0]    r_cur_task;
  logic [NUM_TASKS-1:0] r_mask;

  next_t w_go_first;    // lowest enabled task of the incoming mask
  next_t w_mask_first;  // lowest enabled task of the latched mask (loop wrap)
  next_t w_mask_next;   // next enabled task above the current one
  logic  w_expired;
  logic  w_cur_finish;

  always_comb begin
    w_go_first   = next_enabled(MAX_TASKS'(i_enable), 0);
    w_mask_first = next_enabled(MAX_TASKS'(r_mask), 0);
    w_mask_next  = next_enabled(MAX_TASKS'(r_mask), int'(r_cur_task) + 1);
  end

  // Only the current task's finish is ever looked at.
  assign w_cur_finish = i_finish[r_cur_task];

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_wd
      assign w_expired = 1'b0;
    end else begin : g_wd
      seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_watchdog (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clear  (r_state == START),
        .i_enable (r_state == WAIT),
        .o_expired(w_expired)
      );
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cur_task <= '0;
      r_mask     <= '0;
    end else if (i_abort) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE, DONE, ERROR: begin
          if (i_go) begin
            r_mask <= i_enable;
            if (!w_go_first.found) begin
              r_state <= DONE;
            end else begin
              r_cur_task <= TASK_W'(w_go_first.idx);
              r_state    <= START;
            end
          end
        end
        START: r_state <= WAIT;
        WAIT: begin
          // Finish takes precedence over a watchdog expiry on the same edge.
          if (w_cur_finish) begin
            if (w_mask_next.found) begin
              r_cur_task <= TASK_W'(w_mask_next.idx);
              r_state    <= START;
            end else if (LOOP && w_mask_first.found) begin
              r_cur_task <= TASK_W'(w_mask_first.idx);
              r_state    <= START;
            end else begin
              r_state <= DONE;
            end
          end else if (w_expired) begin
            r_state <= ERROR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_start       = (r_state == START) ? (NUM_TASKS'(1) << r_cur_task) : '0;
  assign o_busy        = (r_state == START) || (r_state == WAIT);
  assign o_done        = (r_state == DONE);
  assign o_timeout_err = (r_state == ERROR);
  assign o_cur_task    = r_cur_task;

endmodule

// File: tb/tb_task_sequencer.sv
// -----------------------------------------------------------------------------
// tb_task_sequencer
// Two sequencers (LOOP=0 and LOOP=1, watchdog 8) share one set of inputs; the
// bench observes one of them at a time. For each run a timeline of expected
// outputs is computed from the enable mask and per-task finish latencies,
// then the run is driven cycle by cycle and every output is compared.
// -----------------------------------------------------------------------------
module tb_task_sequencer;

  localparam int NT = 3;
  localparam int TO = 8;
  localparam int HM = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          go;
  logic          abort;
  logic [NT-1:0] enable;
  logic [NT-1:0] finish;

  logic [NT-1:0] start0, start1;
  logic          busy0, busy1, done0, done1, err0, err1;
  logic [1:0]    cur0, cur1;

  bit            sel;
  logic [NT-1:0] o_start;
  logic          o_busy, o_done, o_err;
  logic [1:0]    o_cur;

  int total = 0;
  int bad   = 0;
  int m_cur = 0;

  logic [NT-1:0] e_start [HM];
  bit            e_busy  [HM];
  bit            e_done  [HM];
  bit            e_err   [HM];
  int            e_cur   [HM];
  int            w_task  [HM];
  bit            f_at    [HM];

  task_sequencer #(.NUM_TASKS(NT), .TIMEOUT_CYCLES(TO), .LOOP(1'b0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_abort(abort),
    .i_enable(enable), .i_finish(finish), .o_start(start0), .o_busy(busy0),
    .o_done(done0), .o_timeout_err(err0), .o_cur_task(cur0)
  );

  task_sequencer #(.NUM_TASKS(NT), .TIMEOUT_CYCLES(TO), .LOOP(1'b1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_abort(abort),
    .i_enable(enable), .i_finish(finish), .o_start(start1), .o_busy(busy1),
    .o_done(done1), .o_timeout_err(err1), .o_cur_task(cur1)
  );

  always_comb begin
    if (sel) begin
      o_start = start1; o_busy = busy1; o_done = done1; o_err = err1; o_cur = cur1;
    end else begin
      o_start = start0; o_busy = busy0; o_done = done0; o_err = err0; o_cur = cur0;
    end
  end

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int c, input bit with_cur, input int cur);
    check($sformatf("c%0d idle start", c), 32'(o_start), 0);
    check($sformatf("c%0d idle busy", c), 32'(o_busy), 0);
    check($sformatf("c%0d idle done", c), 32'(o_done), 0);
    check($sformatf("c%0d idle err", c), 32'(o_err), 0);
    if (with_cur) check($sformatf("c%0d idle cur", c), 32'(o_cur), cur);
  endtask

  function automatic int lowest(input logic [NT-1:0] m);
    for (int b = 0; b < NT; b++) if (m[b]) return b;
    return -1;
  endfunction

  function automatic int next_above(input logic [NT-1:0] m, input int i);
    for (int b = i + 1; b < NT; b++) if (m[b]) return b;
    return -1;
  endfunction

  // One sequence: go in cycle 0, start pulse of the first task in cycle 1.
  // A task with latency d < TO raises finish d cycles into its WAIT; d >= TO
  // never finishes within the watchdog window.
  task automatic run(input bit use_loop, input logic [NT-1:0] mask,
                     input int d0, input int d1, input int d2,
                     input bit pre_abort, input bit end_abort,
                     input int h_arg, input bit ones);
    int d[NT];
    int t, i, n, e_end, h;
    bit ended, hung;
    logic [NT-1:0] f;
    d[0] = d0; d[1] = d1; d[2] = d2;
    sel = use_loop;
    for (int c = 0; c < HM; c++) begin
      e_start[c] = '0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
      e_cur[c] = m_cur; w_task[c] = -1; f_at[c] = 0;
    end
    ended = 0; hung = 0; t = 1; e_end = HM; i = m_cur;
    h = use_loop ? h_arg : HM;
    if (mask == '0) begin
      ended = 1; e_end = 1;
    end else begin
      i = lowest(mask);
      while (!ended && t <= h) begin
        e_start[t] = NT'(1) << i; e_busy[t] = 1; e_cur[t] = i;
        if (d[i] < TO) begin
          for (int k = 1; k <= d[i] + 1; k++) begin
            e_busy[t+k] = 1; e_cur[t+k] = i; w_task[t+k] = i;
          end
          f_at[t+d[i]+1] = 1;
          t = t + d[i] + 2;
          n = next_above(mask, i);
          if (n >= 0) i = n;
          else if (use_loop) i = lowest(mask);
          else begin ended = 1; e_end = t; end
        end else begin
          for (int k = 1; k <= TO; k++) begin
            e_busy[t+k] = 1; e_cur[t+k] = i; w_task[t+k] = i;
          end
          ended = 1; hung = 1; e_end = t + TO + 1;
        end
      end
    end
    for (int c = e_end; c < HM; c++) begin
      e_done[c] = !hung; e_err[c] = hung; e_cur[c] = i;
    end
    if (!use_loop) h = e_end + h_arg;

    if (pre_abort) begin
      @(negedge clk);
      abort = 1'b1; go = 1'b0; finish = NT'($urandom);
      @(negedge clk);
      check_idle(0, 1'b0, 0);
    end else begin
      @(negedge clk);
    end
    abort = 1'b0; go = 1'b1; enable = mask;
    finish = ones ? '1 : NT'($urandom);

    for (int c = 1; c <= h; c++) begin
      @(negedge clk);
      check($sformatf("c%0d start", c), 32'(o_start), 32'(e_start[c]));
      check($sformatf("c%0d busy", c), 32'(o_busy), 32'(e_busy[c]));
      check($sformatf("c%0d done", c), 32'(o_done), 32'(e_done[c]));
      check($sformatf("c%0d err", c), 32'(o_err), 32'(e_err[c]));
      check($sformatf("c%0d cur", c), 32'(o_cur), e_cur[c]);
      abort  = (c == h) && end_abort;
      go     = (e_busy[c] || abort) ? 1'($urandom) : 1'b0;
      enable = NT'($urandom);
      f = ones ? '1 : NT'($urandom);
      if (w_task[c] >= 0) f[w_task[c]] = f_at[c];
      finish = f;
    end
    if (end_abort) begin
      for (int c = h + 1; c <= h + 3; c++) begin
        @(negedge clk);
        check_idle(c, 1'b1, e_cur[h]);
        abort = 1'b0; go = 1'b0; finish = NT'($urandom);
      end
    end
    m_cur = e_cur[h];
    $display("run loop=%0d mask=%b d=%0d/%0d/%0d end=%0d total=%0d bad=%0d",
             use_loop, mask, d0, d1, d2, h, total, bad);
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; abort = 1'b0; enable = '0; finish = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    check_idle(0, 1'b1, 0);
    rst_n = 1'b1;
    m_cur = 0;

    // Directed sequences on the non-looping sequencer.
    run(1'b0, 3'b111, 2, 2, 2, 1'b0, 1'b0, 2, 1'b0);
    run(1'b0, 3'b101, 1, 0, 3, 1'b0, 1'b0, 1, 1'b1);
    run(1'b0, 3'b000, 0, 0, 0, 1'b0, 1'b0, 2, 1'b0);
    run(1'b0, 3'b111, 1, 100, 1, 1'b0, 1'b0, 2, 1'b0);
    run(1'b0, 3'b111, 0, 0, 0, 1'b0, 1'b0, 1, 1'b0);
    run(1'b0, 3'b111, 7, 7, 7, 1'b0, 1'b1, 1, 1'b0);

    for (int r = 0; r < 15; r++) begin
      run(1'b0, NT'($urandom_range(0, 7)), int'($urandom_range(0, 9)),
          int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
          1'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
          ($urandom_range(0, 4) == 0));
    end

    // Reset dropped while a start pulse is on the wire.
    sel = 1'b0;
    @(negedge clk); abort = 1'b1; go = 1'b0;
    @(negedge clk); abort = 1'b0; go = 1'b1; enable = 3'b111; finish = '0;
    @(negedge clk);
    check("rst pre start", 32'(o_start), 32'h1);
    go = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle(1, 1'b1, 0);
    @(negedge clk);
    check_idle(2, 1'b1, 0);
    rst_n = 1'b1;
    m_cur = 0;
    run(1'b0, 3'b110, 0, 1, 2, 1'b0, 1'b0, 1, 1'b0);

    // Looping sequencer.
    run(1'b1, 3'b011, 2, 2, 2, 1'b1, 1'b1, 7, 1'b0);
    for (int r = 0; r < 10; r++) begin
      run(1'b1, NT'($urandom_range(1, 7)), int'($urandom_range(0, 9)),
          int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
          1'b1, 1'b1, int'($urandom_range(5, 60)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
